// File: rtl/imem_loader_if.sv
// Byte-stream handshake that feeds program bytes into the instruction-memory loader.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory writer: assembles a little-endian byte stream into N-bit words,
// stores them sequentially and holds the CPU in reset until the image is complete.
module imem_loader #(
  parameter int N = 32,
  parameter int M = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [M:0]          len,
  imem_loader_if.slave        byte_if,
  output logic [N*(2**M)-1:0] instructions,
  output logic                busy,
  output logic                done,
  output logic                cpu_rst_n
);

  localparam int BPW = N / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [M:0]     DEPTH_L = {1'b1, {M{1'b0}}};
  localparam logic [BCW-1:0] LAST_BC = BCW'(BPW - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [M:0]          len_r;
  logic [M:0]          len_clamp_s;
  logic [M:0]          waddr_r;
  logic [M:0]          waddr_inc_s;
  logic [BCW-1:0]      bytecnt_r;
  logic [N-1:0]        asm_r;
  logic [N-1:0]        word_s;
  logic [N*(2**M)-1:0] mem_r;
  logic                busy_r;
  logic                done_r;
  logic                in_ready_s;
  logic                accept_s;
  logic                last_byte_s;

  // waddr is one bit wider than the address so a full-depth load ends without wrapping
  assign waddr_inc_s = waddr_r + {{M{1'b0}}, 1'b1};

  // Clamp the requested length to the memory depth
  always_comb begin
    if (len > DEPTH_L) begin
      len_clamp_s = DEPTH_L;
    end else begin
      len_clamp_s = len;
    end
  end

  // Merge the incoming byte into the partially assembled word
  always_comb begin
    word_s = asm_r;
    word_s[{bytecnt_r, 3'b000} +: 8] = byte_if.in_data;
  end

  // State register with registered status decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_LOAD);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Next-state logic; start restarts the load from any state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = (len_clamp_s == {(M+1){1'b0}}) ? ST_DONE : ST_LOAD;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOAD: begin
        if (start) begin
          state_nxt_s = (len_clamp_s == {(M+1){1'b0}}) ? ST_DONE : ST_LOAD;
        end else if (last_byte_s && (waddr_inc_s == len_r)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake decode; a start pulse blocks acceptance that cycle
  always_comb begin
    if ((state_r == ST_LOAD) && !start) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    if (in_ready_s && byte_if.in_valid) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (accept_s && (bytecnt_r == LAST_BC)) begin
      last_byte_s = 1'b1;
    end else begin
      last_byte_s = 1'b0;
    end
  end

  // Load bookkeeping: length, word address, byte position and assembly register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r     <= {(M+1){1'b0}};
      waddr_r   <= {(M+1){1'b0}};
      bytecnt_r <= {BCW{1'b0}};
      asm_r     <= {N{1'b0}};
    end else if (start) begin
      len_r     <= len_clamp_s;
      waddr_r   <= {(M+1){1'b0}};
      bytecnt_r <= {BCW{1'b0}};
      asm_r     <= {N{1'b0}};
    end else if (last_byte_s) begin
      waddr_r   <= waddr_inc_s;
      bytecnt_r <= {BCW{1'b0}};
      asm_r     <= {N{1'b0}};
    end else if (accept_s) begin
      bytecnt_r <= bytecnt_r + BCW'(1);
      asm_r     <= word_s;
    end
  end

  // Instruction memory; only the asynchronous reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r <= {(N*(2**M)){1'b0}};
    end else if (last_byte_s) begin
      mem_r[waddr_r[M-1:0]*N +: N] <= word_s;
    end
  end

  assign byte_if.in_ready = in_ready_s;
  assign instructions     = mem_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign cpu_rst_n        = done_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-level model predicts each completed word,
// which is compared against the flat instruction bus the cycle after its final byte.
module tb_imem_loader;
  localparam int N     = 32;
  localparam int M     = 10;
  localparam int DEPTH = 1 << M;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [M:0]         len;
  logic [N*DEPTH-1:0] instructions;
  logic               busy;
  logic               done;
  logic               cpu_rst_n;

  imem_loader_if bus ();

  imem_loader #(.N(N), .M(M)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .byte_if      (bus),
    .instructions (instructions),
    .busy         (busy),
    .done         (done),
    .cpu_rst_n    (cpu_rst_n)
  );

  always #5 clk = ~clk;

  logic [N-1:0]   m_mem [DEPTH];
  logic [N-1:0]   m_asm;
  int             m_waddr;
  int             m_bc;
  int             m_len;
  bit             m_load;
  bit             m_done;
  logic [M+N-1:0] exp_q [$];
  int             total = 0;
  int             bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] dut_word(input int a);
    return instructions[a*N +: N];
  endfunction

  // Scoreboard: a word pushed after its final byte must be on the bus by the next negedge
  always @(negedge clk) begin
    logic [M+N-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("sb_word", {32'd0, dut_word(int'(e[M+N-1:N]))}, {32'd0, e[N-1:0]});
    end
  end

  task automatic model_accept(input logic [7:0] b);
    m_asm[m_bc*8 +: 8] = b;
    m_bc++;
    if (m_bc == N/8) begin
      m_mem[m_waddr] = m_asm;
      exp_q.push_back({m_waddr[M-1:0], m_asm});
      m_bc  = 0;
      m_asm = '0;
      m_waddr++;
      if (m_waddr == m_len) begin
        m_load = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  // Present one byte for one clock; called and returns at posedge+1
  task automatic send_byte(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_val("in_ready", {63'd0, bus.in_ready}, {63'd0, m_load});
    check_val("done", {63'd0, done}, {63'd0, m_done});
    @(posedge clk);
    #1;
    if (m_load) model_accept(b);
  endtask

  task automatic do_start(input int l);
    logic [31:0] lv;
    lv    = l;
    start = 1'b1;
    len   = lv[M:0];
    @(negedge clk);
    check_val("rdy_on_start", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    start   = 1'b0;
    m_len   = (l > DEPTH) ? DEPTH : l;
    m_waddr = 0;
    m_bc    = 0;
    m_asm   = '0;
    m_load  = (m_len != 0);
    m_done  = (m_len == 0);
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check_val({tag, "_busy"}, {63'd0, busy}, {63'd0, m_load});
    check_val({tag, "_done"}, {63'd0, done}, {63'd0, m_done});
    check_val({tag, "_cpurst"}, {63'd0, cpu_rst_n}, {63'd0, m_done});
    @(posedge clk);
    #1;
  endtask

  task automatic mem_check(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dut_word(i) !== m_mem[i]) diffs++;
    end
    check_val(tag, 64'(diffs), 64'd0);
  endtask

  task automatic send_list(input logic [7:0] bl [], input bit drop_valid);
    foreach (bl[i]) send_byte(bl[i]);
    if (drop_valid) bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] t2 [] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] t3 [] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] t4 [] = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst_n        = 1'b0;
    start        = 1'b0;
    len          = '0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    m_load = 1'b0; m_done = 1'b0; m_bc = 0; m_waddr = 0; m_len = 0; m_asm = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Reset state
    #2;
    check_val("rst_ready", {63'd0, bus.in_ready}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_cpurst", {63'd0, cpu_rst_n}, 64'd0);
    check_val("rst_mem_any", {63'd0, |instructions}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // len=0 from IDLE: DONE next cycle, bytes ignored, memory untouched
    bus.in_data  = 8'h5A;
    bus.in_valid = 1'b1;
    do_start(0);
    send_byte(8'h5A);
    bus.in_valid = 1'b0;
    mem_check("len0_mem");
    check_status("len0");

    // Back-to-back two-word load
    do_start(2);
    send_list(t2, 1'b1);
    check_status("t2");
    check_val("t2_w0", {32'd0, dut_word(0)}, 64'h12345678);
    check_val("t2_w1", {32'd0, dut_word(1)}, 64'hDEADBEEF);
    check_val("rdy_before_start", {63'd0, bus.in_ready}, 64'd0);

    // len=1 with in_valid toggling every other cycle
    do_start(1);
    for (int i = 0; i < 4; i++) begin
      send_byte(t3[i]);
      bus.in_valid = 1'b0;
      if (i == 2) check_val("t3_w0_early", {32'd0, dut_word(0)}, 64'h12345678);
      @(posedge clk);
      #1;
    end
    check_val("t3_w0", {32'd0, dut_word(0)}, 64'h04030201);
    check_val("rdy_after_done", {63'd0, bus.in_ready}, 64'd0);
    check_status("t3");

    // Full two-word load, then restart with a single word
    do_start(2);
    for (int i = 0; i < 8; i++) send_byte(8'hAA);
    bus.in_valid = 1'b0;
    do_start(1);
    send_list(t4, 1'b1);
    check_val("t4_w0", {32'd0, dut_word(0)}, 64'h44332211);
    check_val("t4_w1", {32'd0, dut_word(1)}, 64'hAAAAAAAA);
    check_status("t4");
    mem_check("t4_mem");

    // Abort after 6 bytes with a byte on offer during the start pulse
    do_start(2);
    for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i));
    bus.in_data = 8'hEE;
    do_start(2);
    mem_check("abort_mem");
    for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i));
    bus.in_valid = 1'b0;
    check_status("abort");
    check_val("abort_w0", {32'd0, dut_word(0)}, 64'hC3C2C1C0);
    mem_check("reload_mem");

    // Asynchronous reset part-way through a load
    do_start(2);
    for (int i = 0; i < 3; i++) send_byte(8'h90 + 8'(i));
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("arst_mem_any", {63'd0, |instructions}, 64'd0);
    check_val("arst_done", {63'd0, done}, 64'd0);
    check_val("arst_cpurst", {63'd0, cpu_rst_n}, 64'd0);
    check_val("arst_ready", {63'd0, bus.in_ready}, 64'd0);
    check_val("arst_busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_load = 1'b0; m_done = 1'b0; m_bc = 0; m_waddr = 0; m_asm = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Over-long length is clamped to the full memory depth
    do_start(DEPTH + 5);
    for (int i = 0; i < DEPTH * (N/8); i++) send_byte(8'($urandom_range(0, 255)));
    bus.in_valid = 1'b0;
    check_status("clamp");
    check_val("clamp_last", {32'd0, dut_word(DEPTH-1)}, {32'd0, m_mem[DEPTH-1]});
    mem_check("clamp_mem");

    @(negedge clk);
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the CPU instruction-memory interface.
- Accepts a byte stream over a valid/ready handshake and assembles it into N-bit instruction words, little-endian.
- Writes the words sequentially into a register array driven onto the flat instruction bus that the CPU core reads.
- Holds the core in reset until a program image has been completely loaded.

Parameters:
- N, 32, instruction word width in bits; must be a multiple of 8.
- M, 10, log2 of memory depth in words (2**M words).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a new load at word 0.
- len  input  M+1  number of words to load; sampled on start; values above 2**M are clamped to 2**M.
- in_data  input  8  program byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- instructions  output  N*(2**M)  flat memory image; word k occupies bits [k*N +: N].
- busy  output  1  high while in the LOAD state.
- done  output  1  high after a load completes; held until the next start or reset.
- cpu_rst_n  output  1  active-low reset for the CPU core; equals done.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; instructions all zero; in_ready 0, busy 0, done 0, cpu_rst_n 0.
  - Word address, byte counter and assembly register cleared.
- States:
  - IDLE: wait for start.
  - LOAD: accept bytes.
  - DONE: image complete, CPU released.
- Transitions:
  - IDLE, start=1: latch clamped len; waddr=0, bytecnt=0, assembly register cleared. Next state is LOAD, or DONE if len=0.
  - LOAD: a byte is accepted when in_valid && in_ready. It goes to assembly bits [bytecnt*8 +: 8] and bytecnt increments.
  - LOAD, accepting byte N/8-1: the full word (including this byte) is written to word waddr. The write is visible on instructions in the following cycle. Then bytecnt=0 and waddr+1. If waddr+1 == len, go to DONE.
  - LOAD, start=1 (abort/restart): same action as start in IDLE. Memory contents are kept; no byte is accepted that cycle.
  - DONE, start=1: same as start in IDLE; done and cpu_rst_n drop the next cycle.
- in_ready is combinational: (state==LOAD) && !start. in_valid may stay high across cycles; one byte is transferred per cycle while both handshake signals are high.
- busy and done are registered decodes of state. done and cpu_rst_n rise in the cycle after the final byte is accepted, the same cycle the last word becomes visible.
- Write rules:
  - Only words 0..len-1 are written.
  - Words not written keep their previous value. Only rst_n zeroes memory.
  - A partial word (fewer than N/8 bytes) pending at abort is discarded.
- Bytes presented in IDLE or DONE are ignored (in_ready=0).
- With len=2**M, the final write goes to word 2**M-1 and waddr never wraps past the last word.
- If rst_n asserts mid-load, everything clears immediately; no partial state survives.

Test Plan:
- Reset, then start with len=2, stream 78 56 34 12 EF BE AD DE back-to-back -> word0=0x12345678, word1=0xDEADBEEF; done=1 and cpu_rst_n=1 exactly one cycle after the 8th byte; busy=0 afterwards.
- len=1, in_valid toggled every other cycle with bytes 01 02 03 04 -> word0=0x04030201 only after the 4th handshake; in_ready=0 before start and after done.
- Load len=2 (AA.. words), then restart with len=1 and bytes 11 22 33 44 -> word0=0x44332211, word1 unchanged.
- Start with len=0 -> DONE next cycle, no byte accepted, instructions unchanged.
- Mid-load abort after 6 bytes (start pulse with in_valid=1) -> that byte not accepted; the partial word is dropped; reload proceeds from word 0.
- Assert rst_n=0 after 3 of 8 bytes -> instructions all zero, done=0, cpu_rst_n=0, in_ready=0 asynchronously. len=2**M+5 -> clamped; the last write goes to word 2**M-1.
